// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle of the control FSM's datapath-facing signals.
//                master modport = control FSM (drives strobes and selects)
//                slave  modport = datapath / field decoder (drives Op,
//                funct, zero, mem_ready).
//  Signals     : Op[5:0], funct[5:0], zero, mem_ready      (to controller)
//                mem_read, mem_write, ir_write, pc_write,  (from controller)
//                pc_src[1:0], reg_write, regDst[1:0], memToReg[1:0],
//                alu_srcA, alu_srcB[1:0], alu_control[2:0], illegal,
//                state[3:0], cycle_count[CNT_W-1:0], retire_count[CNT_W-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [1:0]       regDst;
    logic [1:0]       memToReg;
    logic             alu_srcA;
    logic [1:0]       alu_srcB;
    logic [2:0]       alu_control;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        input  Op, funct, zero, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_src,
               reg_write, regDst, memToReg, alu_srcA, alu_srcB,
               alu_control, illegal, state, cycle_count, retire_count
    );

    modport slave (
        output Op, funct, zero, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_src,
               reg_write, regDst, memToReg, alu_srcA, alu_srcB,
               alu_control, illegal, state, cycle_count, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle MIPS control FSM. Steps the shared datapath
//                through fetch/decode/execute/memory/writeback one
//                instruction at a time, handshaking with a variable-latency
//                memory and faulting on illegal encodings or memory timeout.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous, active-high
//                bus    - multicycle_control_if.master (see interface file)
//  Parameters  : MEM_TIMEOUT - !mem_ready cycles tolerated before FAULT
//                              (0 = wait forever)
//                CNT_W       - performance counter width
//  Build macro : PERF_COUNT_EN - enables cycle_count / retire_count;
//                undefined ties both to zero with no counter flops.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_R     = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } t_state;

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int c_LAST   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    t_state              r_state;
    t_state              w_next;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_waiting;
    logic                w_timeout;

    // Only the three memory-handshake states can stall on mem_ready.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && !bus.mem_ready &&
                       (r_wait == c_LAST[c_WAIT_W-1:0]);

    // Output decode and next-state logic. Strobes are forced low while reset
    // is asserted so an in-flight memory request drops immediately.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.reg_write   = 1'b0;
        bus.regDst      = 2'b00;
        bus.memToReg    = 2'b00;
        bus.alu_srcA    = 1'b0;
        bus.alu_srcB    = 2'b00;
        bus.alu_control = 3'b000;
        w_next          = r_state;

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.alu_srcB = 2'b01;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_next       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute branch target into ALUOut.
                    bus.alu_srcB = 2'b11;
                    case (bus.Op)
                        6'h00:        w_next = S_EXEC_R;
                        6'h23, 6'h2B: w_next = S_MEM_ADDR;
                        6'h04, 6'h05: w_next = S_BRANCH;
                        6'h08, 6'h0E: w_next = S_EXEC_I;
                        6'h02, 6'h03: w_next = S_JUMP;
                        default:      w_next = S_FAULT;
                    endcase
                end
                S_EXEC_R: begin
                    bus.alu_srcA = 1'b1;
                    case (bus.funct)
                        6'h20: begin bus.alu_control = 3'b000; w_next = S_WB_R; end
                        6'h22: begin bus.alu_control = 3'b001; w_next = S_WB_R; end
                        6'h2A: begin bus.alu_control = 3'b011; w_next = S_WB_R; end
                        6'h08: begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 2'b11;
                            w_next       = S_FETCH;
                        end
                        default: w_next = S_FAULT;
                    endcase
                end
                S_EXEC_I: begin
                    bus.alu_srcA    = 1'b1;
                    bus.alu_srcB    = 2'b10;
                    bus.alu_control = (bus.Op == 6'h0E) ? 3'b010 : 3'b000;
                    w_next          = S_WB_I;
                end
                S_WB_R: begin
                    bus.reg_write = 1'b1;
                    bus.regDst    = 2'b01;
                    w_next        = S_FETCH;
                end
                S_WB_I: begin
                    bus.reg_write = 1'b1;
                    w_next        = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bus.alu_srcA = 1'b1;
                    bus.alu_srcB = 2'b10;
                    w_next       = (bus.Op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) w_next = S_WB_MEM;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) w_next = S_FETCH;
                end
                S_WB_MEM: begin
                    bus.reg_write = 1'b1;
                    bus.memToReg  = 2'b01;
                    w_next        = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_srcA    = 1'b1;
                    bus.alu_control = 3'b001;
                    bus.pc_src      = 2'b01;
                    bus.pc_write    = ((bus.Op == 6'h04) &&  bus.zero) ||
                                      ((bus.Op == 6'h05) && !bus.zero);
                    w_next          = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                    if (bus.Op == 6'h03) begin
                        bus.reg_write = 1'b1;
                        bus.regDst    = 2'b10;
                        bus.memToReg  = 2'b10;
                    end
                    w_next = S_FETCH;
                end
                S_FAULT:  w_next = S_FAULT;
                default:  w_next = S_FAULT;
            endcase

            if (w_timeout) begin
                w_next = S_FAULT;
            end
        end
    end

    assign bus.state   = r_state;
    assign bus.illegal = (r_state == S_FAULT) && !reset;

`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_retire;
    logic             w_retire;

    assign w_retire         = (w_next == S_FETCH) && (r_state != S_FETCH);
    assign bus.cycle_count  = r_cycle;
    assign bus.retire_count = r_retire;
`else
    assign bus.cycle_count  = {CNT_W{1'b0}};
    assign bus.retire_count = {CNT_W{1'b0}};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
`ifdef PERF_COUNT_EN
            r_cycle  <= '0;
            r_retire <= '0;
`endif
        end else begin
            r_state <= w_next;
            // Wait counter restarts on every state change, so it measures
            // consecutive stalled cycles within one handshake state.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && !bus.mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
`ifdef PERF_COUNT_EN
            if (r_state != S_FAULT) r_cycle  <= r_cycle + 1'b1;
            if (w_retire)           r_retire <= r_retire + 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire
